// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bit counter width: must hold WIDTH itself, so WIDTH=32 needs 6 bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, one result bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res, res_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic             accept, last;

  fa_cell u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result register shifted right with the new bit entering at the MSB.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_s;
  end else begin : g_res_wn
    assign res_shift = {fa_s, res[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; a start in DONE chains straight into the next add.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  // Operand/result shifting and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      res   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= res_shift;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_shift;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, cin0, busy0, done0, cout0;
  logic [7:0] a0, b0, sum0;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  logic       chk_en;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
  endtask

  // Model: an add takes w busy cycles, then the full sum appears with a done pulse.
  typedef struct packed {
    logic [7:0]  rem;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic [32:0] pend;
  } model_t;

  model_t m0, m1;

  function automatic model_t step(input model_t m, input logic st,
                                  input logic [32:0] total, input int w);
    model_t n;
    n      = m;
    n.done = 1'b0;
    if (m.rem != 0) begin
      n.rem = m.rem - 8'd1;
      if (m.rem == 8'd1) begin
        n.done = 1'b1;
        n.sum  = 32'(total_mask(m.pend, w));
        n.cout = m.pend[w];
      end
    end else if (st) begin
      n.pend = total;
      n.rem  = 8'(w);
    end
    return n;
  endfunction

  function automatic logic [32:0] total_mask(input logic [32:0] v, input int w);
    return v & ((33'd1 << w) - 33'd1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, start0, 33'(a0) + 33'(b0) + 33'(cin0), 8);
      m1 <= step(m1, start1, 33'(a1) + 33'(b1) + 33'(cin1), 1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("w8 busy", 32'(busy0), 32'(m0.rem != 0));
      check("w8 done", 32'(done0), 32'(m0.done));
      check("w8 sum",  32'(sum0),  m0.sum);
      check("w8 cout", 32'(cout0), 32'(m0.cout));
      check("w1 busy", 32'(busy1), 32'(m1.rem != 0));
      check("w1 done", 32'(done1), 32'(m1.done));
      check("w1 sum",  32'(sum1),  m1.sum);
      check("w1 cout", 32'(cout1), 32'(m1.cout));
    end
  end

  // Counts negedges until done0, bounded.
  task automatic wait_done0(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done0) seen = 1;
    end
    if (!seen) check("w8 done timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_done1(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done1) seen = 1;
    end
    if (!seen) check("w1 done timeout", 32'(0), 32'(1));
  endtask

  task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    start0 = 1'b1; a0 = a; b0 = b; cin0 = c;
    @(posedge clk); #1;
    start0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    wait_done0(lat);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c, output int lat);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    wait_done1(lat);
  endtask

  initial begin
    int lat, seen;
    logic [7:0] ra, rb;
    logic       rc;
    rst_n = 1'b0; chk_en = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy0), 32'(0));
    check("reset done", 32'(done0), 32'(0));
    check("reset sum",  32'(sum0),  32'(0));
    check("reset cout", 32'(cout0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    run_op0(8'h5A, 8'h3C, 1'b0, lat);
    check("t1 latency", 32'(lat), 32'(9));
    check("t1 sum", 32'(sum0), 32'h96);
    check("t1 cout", 32'(cout0), 32'(0));
    @(posedge clk); #1;

    run_op0(8'hFF, 8'h01, 1'b0, lat);
    check("t2a sum", 32'(sum0), 32'h00);
    check("t2a cout", 32'(cout0), 32'(1));
    @(posedge clk); #1;
    run_op0(8'hFF, 8'hFF, 1'b1, lat);
    check("t2b sum", 32'(sum0), 32'hFF);
    check("t2b cout", 32'(cout0), 32'(1));
    @(posedge clk); #1;

    // Start pulsed in the third SHIFT cycle must be ignored.
    start0 = 1'b1; a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start0 = 1'b1; a0 = 8'hAA; b0 = 8'h55;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0(lat);
    check("t3 latency", 32'(lat), 32'(6));
    check("t3 sum", 32'(sum0), 32'h30);
    check("t3 cout", 32'(cout0), 32'(0));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy0 || done0) seen++;
    end
    check("t3 no second op", 32'(seen), 32'(0));
    @(posedge clk); #1;

    // Back-to-back: start presented during the DONE cycle.
    run_op0(8'h11, 8'h22, 1'b0, lat);
    check("t4a sum", 32'(sum0), 32'h33);
    start0 = 1'b1; a0 = 8'h01; b0 = 8'h02; cin0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0(lat);
    check("t4 done gap", 32'(lat), 32'(9));
    check("t4 sum", 32'(sum0), 32'h04);
    check("t4 cout", 32'(cout0), 32'(0));
    @(posedge clk); #1;

    // Reset in the fourth SHIFT cycle clears everything, no done follows.
    start0 = 1'b1; a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t5 busy", 32'(busy0), 32'(0));
    check("t5 done", 32'(done0), 32'(0));
    check("t5 sum",  32'(sum0),  32'(0));
    check("t5 cout", 32'(cout0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0) seen++;
    end
    check("t5 no done", 32'(seen), 32'(0));
    @(posedge clk); #1;
    run_op0(8'h80, 8'h80, 1'b0, lat);
    check("t5 sum", 32'(sum0), 32'h00);
    check("t5 cout", 32'(cout0), 32'(1));
    @(posedge clk); #1;

    // Random operands, sometimes chained directly from the DONE cycle.
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op0(ra, rb, rc, lat);
      check("rnd8 latency", 32'(lat), 32'(9));
      check("rnd8 result", 32'({cout0, sum0}), 32'(ra) + 32'(rb) + 32'(rc));
    end
    @(posedge clk); #1;

    // WIDTH=1 build.
    run_op1(1'b1, 1'b1, 1'b1, lat);
    check("w1 latency", 32'(lat), 32'(2));
    check("w1 111", 32'({cout1, sum1}), 32'(3));
    @(posedge clk); #1;
    run_op1(1'b0, 1'b1, 1'b0, lat);
    check("w1 010", 32'({cout1, sum1}), 32'(1));
    for (int i = 0; i < 100; i++) begin
      if (($urandom & 1) != 0) begin
        @(posedge clk); #1;
      end
      ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rc = 1'($urandom);
      run_op1(ra[0], rb[0], rc, lat);
      check("rnd1 latency", 32'(lat), 32'(2));
      check("rnd1 result", 32'({cout1, sum1}), 32'(ra) + 32'(rb) + 32'(rc));
    end
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder for WIDTH-bit operands.
- Loads two operands and a carry-in, then streams one bit per clock through a single 1-bit full-adder cell with a registered carry.
- Presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly upstream of the datapath consumers that previously used parallel full-adder chains; trades WIDTH cycles of latency for one adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk    input   1      single system clock; all state changes on the rising edge
- rst_n  input   1      asynchronous, active-low reset
- start  input   1      request to begin an addition; sampled only when ready
- a      input   WIDTH  operand A; sampled on the accepting edge
- b      input   WIDTH  operand B; sampled on the accepting edge
- cin    input   1      carry-in; sampled on the accepting edge
- busy   output  1      high while bits are being shifted
- done   output  1      one-cycle pulse; sum and cout are valid from this cycle
- sum    output  WIDTH  registered result (a + b + cin) mod 2^WIDTH
- cout   output  1      registered carry out of bit WIDTH-1

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and bit counter are also 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept rule: start is accepted on a rising edge when state is IDLE or DONE. Start in DONE gives back-to-back operation.
- Accepting edge:
  - opA<=a, opB<=b, carry<=cin, cnt<=0.
  - Result shift register cleared.
  - state<=SHIFT.
- Each SHIFT edge:
  - s = opA[0]^opB[0]^carry.
  - carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1, zero fill.
  - Result register shifts right with s inserted at the MSB.
  - cnt <= cnt+1.
- On the SHIFT edge where cnt==WIDTH-1:
  - state<=DONE.
  - sum <= final result register contents, including the bit computed this edge.
  - cout <= new carry.
- DONE lasts exactly one cycle, then goes to IDLE unless start is accepted.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH. The SHIFT phase spans exactly WIDTH cycles.
- sum and cout change only at completion. They hold the last result through IDLE and through the next operation, until the next completion.
- Ignored start: start while busy (SHIFT) is ignored. Operands in flight are unaffected and no queueing occurs.
- a, b and cin are don't-care except on the accepting edge.
- WIDTH=1: SHIFT lasts one cycle and done rises 1 cycle after the accepting edge's cycle.
- Counter width: clog2(WIDTH+1) bits. It must not overflow at WIDTH=32.
- Reset mid-operation: immediate return to reset values, including clearing sum and cout. The partial result is discarded; no done pulse.
- Overflow: wrap-around beyond WIDTH bits is reported only via cout; sum is modulo 2^WIDTH.

Decomposition:
- Package serial_adder_pkg:
  - State encoding constants IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Default WIDTH constant 8.
  - A clog2-based counter-width function.
- Sub-module fa_cell: purely combinational 1-bit full adder.
  - Inputs x, y, ci; outputs s, co.
  - s = x^y^ci; co = majority.
  - Instantiated once; carry register and FSM stay in serial_adder.

Test Plan:
- a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, then done pulse with sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start op a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 at cycle 3 of SHIFT -> single done with sum=0x30, cout=0; no second operation starts.
- Assert start in the DONE cycle with a=0x01, b=0x02, cin=1 -> next done exactly 9 cycles after the first done, with sum=0x04.
- Deassert rst_n at SHIFT cycle 4, release -> all outputs 0 immediately and no done. Then a=0x80, b=0x80 -> sum=0x00, cout=1.
- 1000 random a, b, cin at WIDTH=8 plus a WIDTH=1 build -> {cout,sum} == a+b+cin. done is exactly WIDTH cycles after each accepted start, and sum is stable between completions.
